ultrasonic_scheduler: RTL and testbench
=======================================

Name: ultrasonic_scheduler

Overview:
Time-multiplexes one echo-ranging engine across NUM_SENSORS ultrasonic sensors in round-robin order. For each slot it:
- issues the trigger pulse,
- waits for the echo rising edge,
- measures the echo high time in clk cycles,
- enforces a holdoff so ringing from one sensor does not corrupt the next.
Results are published as a one-cycle valid pulse carrying sensor id and raw width, consumed by the distance comparator / line-follower decision logic.

Parameters:
NUM_SENSORS, 2, number of sensors polled; legal range 2..4.
TRIG_CYCLES, 1000, trigger high time in clk cycles (10 us at 100 MHz).
ECHO_TIMEOUT, 4000000, max cycles waiting for rise, and max cycles measuring; must be < 2^23.
HOLDOFF_CYCLES, 2000000, idle cycles after every slot before the next trigger.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  run polling while high
echo  input  NUM_SENSORS  echo lines, already synchronised upstream; bit i = sensor i
trigger  output  NUM_SENSORS  trigger lines, at most one bit high at any time
meas_valid  output  1  one-cycle pulse, result fields valid
meas_id  output  2  sensor index of result
meas_width  output  23  echo high time in cycles, saturated at ECHO_TIMEOUT
meas_timeout  output  1  result is a timeout (no echo, or echo too long)
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (async, any state): FSM=IDLE, slot index=0, counter=0, trigger=0, meas_valid=0, meas_id=0, meas_width=0, meas_timeout=0, busy=0. Reset mid-trigger drops trigger in the same cycle.
- Single 23-bit counter shared by all states; cleared on every state transition.
- States:
  - IDLE: if enable=1, go to TRIG next cycle; else stay.
  - TRIG: trigger[slot]=1 for exactly TRIG_CYCLES cycles, then WAIT_RISE.
  - WAIT_RISE: trigger=0. Requires a true rising edge, i.e. echo[slot] sampled low then high; a line already high on entry is not a rise until it has gone low. On rise go to MEASURE with counter=1. If counter reaches ECHO_TIMEOUT first: emit result width=ECHO_TIMEOUT, timeout=1, then HOLDOFF.
  - MEASURE: counter increments each cycle echo[slot] is sampled high.
    - First cycle echo[slot] is sampled low: next edge meas_valid=1, meas_width=counter, meas_timeout=0, then HOLDOFF.
    - If counter reaches ECHO_TIMEOUT while echo is still high: width=ECHO_TIMEOUT, timeout=1, then HOLDOFF.
  - HOLDOFF: wait HOLDOFF_CYCLES. Slot advances (NUM_SENSORS-1 wraps to 0) on entry. On exit go to TRIG if enable=1, else IDLE.
- meas_id/meas_width/meas_timeout hold last result until the next meas_valid.
- Exactly one meas_valid per slot.
- enable deasserted mid-slot: current slot completes, including result and holdoff, then IDLE. Slot index is retained for resume.
- Echo activity on non-selected sensors is ignored.
- busy = (state != IDLE).

Optional Feature:
ULTRASONIC_SKIP_MASK_EN
- With it: adds input sensor_mask[NUM_SENSORS-1:0]; 1 = skip sensor.
  - Slot advance selects the next unmasked index in round-robin order.
  - If all sensors are masked, exit HOLDOFF or IDLE to IDLE and stay there until a bit clears.
  - A mask change never aborts a slot in progress.
- Without it: no port; all sensors are polled in fixed order 0,1,..,NUM_SENSORS-1.

Test Plan:
Bench parameters: NUM_SENSORS=2, TRIG_CYCLES=10, ECHO_TIMEOUT=100, HOLDOFF_CYCLES=20.
1. Reset, enable=1, echo[0] high 37 cycles starting 5 cycles after trigger fall -> trigger[0] high exactly 10 cycles; meas_valid with id=0, width=37, timeout=0.
2. No echo on sensor 1 -> meas_valid 100 cycles after trigger[1] falls, with id=1, width=100, timeout=1; next trigger[0] follows after 20-cycle holdoff.
3. echo[0] stuck high from before trigger -> no MEASURE entry; timeout result id=0, width=100.
4. echo[1] high 250 cycles -> width=100 saturated, timeout=1; exactly one meas_valid for the slot.
5. enable dropped during MEASURE of sensor 0 -> result still emitted, busy falls after holdoff; re-enable -> first trigger is trigger[1].
6. Assert reset during TRIG -> trigger=0 and all outputs 0 immediately, without waiting for clk; after release with enable=1, polling restarts at sensor 0.

Source files
------------

// File: rtl/ultrasonic_scheduler_if.sv
// Sensor-side bundle for ultrasonic_scheduler: polling control, echo/trigger lines and result bus.
// ULTRASONIC_SKIP_MASK_EN adds the per-sensor skip mask.
interface ultrasonic_scheduler_if #(
  parameter int unsigned NUM_SENSORS = 2
);
  localparam int unsigned ID_W    = 2;
  localparam int unsigned WIDTH_W = 23;

  logic                   enable;
  logic [NUM_SENSORS-1:0] echo;
  logic [NUM_SENSORS-1:0] trigger;
  logic                   meas_valid;
  logic [ID_W-1:0]        meas_id;
  logic [WIDTH_W-1:0]     meas_width;
  logic                   meas_timeout;
  logic                   busy;
`ifdef ULTRASONIC_SKIP_MASK_EN
  logic [NUM_SENSORS-1:0] sensor_mask;
`endif

  modport master (
`ifdef ULTRASONIC_SKIP_MASK_EN
    input  sensor_mask,
`endif
    input  enable, echo,
    output trigger, meas_valid, meas_id, meas_width, meas_timeout, busy
  );

  modport slave (
`ifdef ULTRASONIC_SKIP_MASK_EN
    output sensor_mask,
`endif
    output enable, echo,
    input  trigger, meas_valid, meas_id, meas_width, meas_timeout, busy
  );
endinterface

// File: rtl/ultrasonic_scheduler.sv
// Round-robin echo-ranging engine shared across NUM_SENSORS ultrasonic sensors.
// Optional ULTRASONIC_SKIP_MASK_EN: skip sensors whose sensor_mask bit is set.
module ultrasonic_scheduler #(
  parameter int unsigned NUM_SENSORS    = 2,
  parameter int unsigned TRIG_CYCLES    = 1000,
  parameter int unsigned ECHO_TIMEOUT   = 4000000,
  parameter int unsigned HOLDOFF_CYCLES = 2000000
) (
  input  logic clk,
  input  logic reset,
  ultrasonic_scheduler_if.master bus
);
  localparam int unsigned CNT_W = 23;
  localparam int unsigned ID_W  = 2;
  localparam int unsigned EXT_W = 4;
  localparam logic [EXT_W-1:0] VALID_MASK = EXT_W'((5'd1 << NUM_SENSORS) - 5'd1);
  localparam logic [CNT_W-1:0] TRIG_LAST  = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(ECHO_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_WIDTH   = CNT_W'(ECHO_TIMEOUT);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(NUM_SENSORS - 1);

  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_HOLDOFF} state_e;

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        slot_q, slot_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   armed_q, armed_d;
  logic [NUM_SENSORS-1:0] trigger_q, trigger_d;
  logic                   meas_valid_q, meas_valid_d;
  logic [ID_W-1:0]        meas_id_q, meas_id_d;
  logic [CNT_W-1:0]       meas_width_q, meas_width_d;
  logic                   meas_timeout_q, meas_timeout_d;
  logic                   busy_q, busy_d;

  logic [EXT_W-1:0] echo_ext, skip_ext;
  logic             echo_sel, any_free;
  logic             emit, emit_to;
  logic [CNT_W-1:0] emit_width;
  logic [ID_W-1:0]  slot_next;

  assign echo_ext = EXT_W'(bus.echo);
`ifdef ULTRASONIC_SKIP_MASK_EN
  assign skip_ext = EXT_W'(bus.sensor_mask);
`else
  assign skip_ext = '0;
`endif
  assign echo_sel  = echo_ext[slot_q];
  assign any_free  = |(~skip_ext & VALID_MASK);
  assign slot_next = (slot_q == LAST_ID) ? '0 : slot_q + ID_W'(1);

  // First unskipped index at or after start, in round-robin order.
  function automatic logic [ID_W-1:0] pick(input logic [ID_W-1:0] start,
                                           input logic [EXT_W-1:0] skip);
    logic [ID_W-1:0] idx;
    logic            found;
    pick  = start;
    idx   = start;
    found = 1'b0;
    for (int i = 0; i < int'(NUM_SENSORS); i++) begin
      if (!found && !skip[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = (idx == LAST_ID) ? '0 : idx + ID_W'(1);
    end
  endfunction

  always_comb begin
    state_d        = state_q;
    slot_d         = slot_q;
    cnt_d          = cnt_q;
    armed_d        = armed_q;
    meas_valid_d   = 1'b0;
    meas_id_d      = meas_id_q;
    meas_width_d   = meas_width_q;
    meas_timeout_d = meas_timeout_q;
    emit           = 1'b0;
    emit_to        = 1'b0;
    emit_width     = '0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.enable && any_free) begin
          state_d = S_TRIG;
          slot_d  = pick(slot_q, skip_ext);
        end
      end
      S_TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = S_WAIT_RISE;
          cnt_d   = '0;
          armed_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // A rise needs a low sample seen inside this state, so a line stuck high never counts.
      S_WAIT_RISE: begin
        if (armed_q && echo_sel) begin
          state_d = S_MEASURE;
          cnt_d   = CNT_W'(1);
        end else if (cnt_q == TO_LAST) begin
          emit       = 1'b1;
          emit_width = TO_WIDTH;
          emit_to    = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          armed_d = !echo_sel;
        end
      end
      S_MEASURE: begin
        if (!echo_sel) begin
          emit       = 1'b1;
          emit_width = cnt_q;
        end else if (cnt_q == TO_LAST) begin
          emit       = 1'b1;
          emit_width = TO_WIDTH;
          emit_to    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLDOFF: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          if (bus.enable && any_free) begin
            state_d = S_TRIG;
            slot_d  = pick(slot_q, skip_ext);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Publish the result and advance to the next slot on entry to holdoff.
    if (emit) begin
      meas_valid_d   = 1'b1;
      meas_id_d      = slot_q;
      meas_width_d   = emit_width;
      meas_timeout_d = emit_to;
      state_d        = S_HOLDOFF;
      cnt_d          = '0;
      slot_d         = pick(slot_next, skip_ext);
    end

    trigger_d = (state_d == S_TRIG) ? NUM_SENSORS'(EXT_W'(1) << slot_d) : '0;
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      slot_q         <= '0;
      cnt_q          <= '0;
      armed_q        <= 1'b0;
      trigger_q      <= '0;
      meas_valid_q   <= 1'b0;
      meas_id_q      <= '0;
      meas_width_q   <= '0;
      meas_timeout_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      slot_q         <= slot_d;
      cnt_q          <= cnt_d;
      armed_q        <= armed_d;
      trigger_q      <= trigger_d;
      meas_valid_q   <= meas_valid_d;
      meas_id_q      <= meas_id_d;
      meas_width_q   <= meas_width_d;
      meas_timeout_q <= meas_timeout_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.trigger      = trigger_q;
  assign bus.meas_valid   = meas_valid_q;
  assign bus.meas_id      = meas_id_q;
  assign bus.meas_width   = meas_width_q;
  assign bus.meas_timeout = meas_timeout_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Self-checking bench for ultrasonic_scheduler: vector table, random slots against a
// behavioural echo model, and hand sequences for enable drop and asynchronous reset.
module tb_ultrasonic_scheduler;
  localparam int NS   = 2;
  localparam int TRIG = 10;
  localparam int TO   = 100;
  localparam int HO   = 20;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  ultrasonic_scheduler_if #(.NUM_SENSORS(NS)) bus ();

  ultrasonic_scheduler #(
    .NUM_SENSORS(NS), .TRIG_CYCLES(TRIG), .ECHO_TIMEOUT(TO), .HOLDOFF_CYCLES(HO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;
  int exp_slot = 0;

  typedef struct {
    int d;      // cycles after trigger fall before echo rises
    int w;      // echo high cycles (0 = no echo)
    bit stuck;  // echo high from before the trigger
    bit drop;   // drop enable while measuring
    int exp_w;
    bit exp_to;
    int lat;    // cycles from trigger fall to meas_valid
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Result of one slot from the echo shape alone: a valid rise needs a low sample first
  // and must land before the wait window closes; pulses reaching the limit saturate.
  function automatic void model(input int d, input int w, input bit stuck,
                                output int ew, output bit eto, output int lat);
    bit rise;
    rise = !stuck && (w > 0) && (d >= 1) && (d <= TO - 1);
    if (!rise) begin
      ew = TO; eto = 1'b1; lat = TO;
    end else if (w >= TO) begin
      ew = TO; eto = 1'b1; lat = d + TO;
    end else begin
      ew = w; eto = 1'b0; lat = d + w + 1;
    end
  endfunction

  task automatic run_slot(input int d, input int w, input bit stuck, input bit drop,
                          input bit noise, input int exp_w, input bit exp_to, input int lat);
    int id, k, hi, vcount, vk, endk;
    logic [NS-1:0] onehot;
    id     = exp_slot;
    onehot = NS'(1) << id;
    bus.echo[id] = stuck;
    k = 0;
    while (bus.trigger == '0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("trigger_select", bus.trigger, onehot);
    hi = 0;
    while (bus.trigger != '0 && hi < 50) begin
      hi++;
      @(negedge clk);
    end
    check("trigger_length", hi, TRIG);
    vcount = 0; vk = -1; endk = -1;
    for (k = 0; k < 600; k++) begin
      if (k > 0 && (bus.trigger != '0 || !bus.busy)) begin
        endk = k;
        break;
      end
      if (bus.meas_valid) begin
        vcount++;
        if (vk < 0) begin
          vk = k;
          check("meas_id", bus.meas_id, id);
          check("meas_width", bus.meas_width, exp_w);
          check("meas_timeout", bus.meas_timeout, exp_to);
        end
      end
      if (drop && k == d + 2) bus.enable = 1'b0;
      bus.echo[id] = stuck || (k >= d && k < d + w);
      if (noise) bus.echo[1 - id] = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.echo = '0;
    check("valid_latency", vk, lat);
    check("valid_count", vcount, 1);
    check("holdoff_end", endk, lat + HO);
    check("busy_at_end", bus.busy, !drop);
    exp_slot = (id + 1) % NS;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, w, ew, lat, k;
    bit stuck, eto;

    tbl[0]  = '{d:5,   w:37,  stuck:0, drop:0, exp_w:37,  exp_to:0, lat:43};
    tbl[1]  = '{d:0,   w:0,   stuck:0, drop:0, exp_w:100, exp_to:1, lat:100};
    tbl[2]  = '{d:0,   w:0,   stuck:1, drop:0, exp_w:100, exp_to:1, lat:100};
    tbl[3]  = '{d:3,   w:250, stuck:0, drop:0, exp_w:100, exp_to:1, lat:103};
    tbl[4]  = '{d:4,   w:20,  stuck:0, drop:1, exp_w:20,  exp_to:0, lat:25};
    tbl[5]  = '{d:1,   w:1,   stuck:0, drop:0, exp_w:1,   exp_to:0, lat:3};
    tbl[6]  = '{d:99,  w:1,   stuck:0, drop:0, exp_w:1,   exp_to:0, lat:101};
    tbl[7]  = '{d:100, w:5,   stuck:0, drop:0, exp_w:100, exp_to:1, lat:100};
    tbl[8]  = '{d:2,   w:99,  stuck:0, drop:0, exp_w:99,  exp_to:0, lat:102};
    tbl[9]  = '{d:2,   w:100, stuck:0, drop:0, exp_w:100, exp_to:1, lat:102};
    tbl[10] = '{d:0,   w:5,   stuck:0, drop:0, exp_w:100, exp_to:1, lat:100};

    bus.enable = 1'b0;
    bus.echo   = '0;
`ifdef ULTRASONIC_SKIP_MASK_EN
    bus.sensor_mask = '0;
`endif
    #1 reset = 1'b1;
    #1;
    check("rst_trigger", bus.trigger, 0);
    check("rst_valid", bus.meas_valid, 0);
    check("rst_id", bus.meas_id, 0);
    check("rst_width", bus.meas_width, 0);
    check("rst_timeout", bus.meas_timeout, 0);
    check("rst_busy", bus.busy, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bus.enable = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_slot(tbl[i].d, tbl[i].w, tbl[i].stuck, tbl[i].drop, 1'b1,
               tbl[i].exp_w, tbl[i].exp_to, tbl[i].lat);
      if (tbl[i].drop) begin
        repeat (5) @(negedge clk);
        check("idle_busy", bus.busy, 0);
        check("idle_trigger", bus.trigger, 0);
        bus.enable = 1'b1;
      end
    end

    for (int i = 0; i < 16; i++) begin
      d     = $urandom_range(0, 110);
      w     = $urandom_range(0, 130);
      stuck = ($urandom_range(0, 9) == 0);
      model(d, w, stuck, ew, eto, lat);
      run_slot(d, w, stuck, 1'b0, 1'b1, ew, eto, lat);
    end

    // Asynchronous reset while a trigger is high.
    k = 0;
    while (bus.trigger == '0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_trigger", bus.trigger, 0);
    check("mid_rst_valid", bus.meas_valid, 0);
    check("mid_rst_id", bus.meas_id, 0);
    check("mid_rst_width", bus.meas_width, 0);
    check("mid_rst_timeout", bus.meas_timeout, 0);
    check("mid_rst_busy", bus.busy, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_slot = 0;
    model(7, 12, 1'b0, ew, eto, lat);
    run_slot(7, 12, 1'b0, 1'b0, 1'b1, ew, eto, lat);

    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end
endmodule
